sb_tx_framer: RTL and testbench

Sideband transmit framer for the USB4 logical layer. It sits on the transmit path opposite the sideband receive transaction FSM. It builds AT frames (DLE, STX, header, data, CRC, DLE, ETX) and LT frames (DLE, LSE, CLSE), applies DLE byte stuffing, and serializes each symbol onto sbtx as a 10-bit character: start bit 0, 8 data bits LSB-first, stop bit 1.

---
 rtl/sb_tx_framer.sv | 221 ++++++++++++++++++++++
 tb/tb_sb_tx_framer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_framer.sv
// USB4 sideband transmit framer: builds AT/LT frames with DLE stuffing and CRC-16,
// then serializes each symbol as start bit, 8 data bits LSB-first, stop bit.
module sb_tx_framer #(
  parameter int          BIT_CYCLES = 1,
  parameter int          DATA_BYTES = 3,
  parameter logic [15:0] CRC_INIT   = 16'hFFFF,
  parameter logic [7:0]  DLE_SYM    = 8'hFE,
  parameter logic [7:0]  ETX_SYM    = 8'h40
) (
  input  logic                    sb_clk,
  input  logic                    rst,
  input  logic                    at_req,
  input  logic                    at_cmd,
  input  logic [7:0]              at_addr,
  input  logic                    at_rw,
  input  logic [6:0]              at_len,
  input  logic                    at_with_data,
  input  logic [8*DATA_BYTES-1:0] at_data,
  input  logic                    lt_req,
  input  logic [7:0]              lt_lse,
  input  logic                    disconnect,
  output logic                    busy,
  output logic                    done,
  output logic                    sbtx
);

  localparam int         IDX_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BYTES - 1);
  localparam logic [3:0] BC_LAST  = 4'(BIT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, DLE1, STX, ADDR, HDR, DATA, CRC_LO, CRC_HI, DLE2, ETX,
    LT_DLE, LT_LSE, LT_CLSE
  } state_t;

  typedef struct packed {
    logic                    cmd;
    logic [7:0]              addr;
    logic                    rw;
    logic [6:0]              len;
    logic                    wd;
    logic [8*DATA_BYTES-1:0] data;
    logic [7:0]              lse;
  } req_t;

  state_t           state_q, state_d, nxt_st;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       cyc_cnt_q, cyc_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             stuff_q, stuff_d;
  logic [15:0]      crc_q, crc_d;
  logic [7:0]       sym_q, sym_d, nxt_byte;
  req_t             req_q, req_d;
  logic             accept;

  // CRC-16 poly 8005, message bits consumed LSB-first within each byte
  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [7:0] sym_byte(input state_t st, input logic [IDX_W-1:0] idx,
                                          input req_t r, input logic [15:0] crc);
    logic [7:0] b;
    b = DLE_SYM;
    case (st)
      STX:     b = r.cmd ? 8'h05 : 8'h04;
      ADDR:    b = r.addr;
      HDR:     b = {r.rw, r.len};
      DATA:    b = r.data[{idx, 3'b000} +: 8];
      CRC_LO:  b = crc[7:0];
      CRC_HI:  b = crc[15:8];
      ETX:     b = ETX_SYM;
      LT_LSE:  b = r.lse;
      LT_CLSE: b = ~r.lse;
      default: b = DLE_SYM;
    endcase
    return b;
  endfunction

  function automatic logic is_stuffable(input state_t st);
    return (st == ADDR) || (st == HDR) || (st == DATA) || (st == CRC_LO) || (st == CRC_HI);
  endfunction

  function automatic logic feeds_crc(input state_t st);
    return (st == STX) || (st == ADDR) || (st == HDR) || (st == DATA);
  endfunction

  assign accept = (state_q == IDLE) && !disconnect && (lt_req || at_req);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    idx_d     = idx_q;
    stuff_d   = stuff_q;
    crc_d     = crc_q;
    sym_d     = sym_q;
    req_d     = req_q;
    nxt_st    = state_q;
    nxt_byte  = sym_q;
    if (disconnect) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
      cyc_cnt_d = '0;
      idx_d     = '0;
      stuff_d   = 1'b0;
      crc_d     = CRC_INIT;
    end else if (accept) begin
      req_d     = '{cmd: at_cmd, addr: at_addr, rw: at_rw, len: at_len,
                    wd: at_with_data, data: at_data, lse: lt_lse};
      state_d   = lt_req ? LT_DLE : DLE1;
      busy_d    = 1'b1;
      bit_cnt_d = '0;
      cyc_cnt_d = '0;
      idx_d     = '0;
      stuff_d   = 1'b0;
      crc_d     = CRC_INIT;
      sym_d     = DLE_SYM;
    end else if (busy_q) begin
      if (cyc_cnt_q != BC_LAST) begin
        cyc_cnt_d = cyc_cnt_q + 4'd1;
      end else begin
        cyc_cnt_d = '0;
        if (bit_cnt_q != 4'd9) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
          bit_cnt_d = '0;
          // A DLE inside the body is resent once; the copy never touches the CRC
          if (is_stuffable(state_q) && (sym_q == DLE_SYM) && !stuff_q) begin
            stuff_d = 1'b1;
          end else begin
            stuff_d = 1'b0;
            case (state_q)
              DLE1:    nxt_st = STX;
              STX:     nxt_st = ADDR;
              ADDR:    nxt_st = HDR;
              HDR: begin
                nxt_st = req_q.wd ? DATA : CRC_LO;
                idx_d  = '0;
              end
              DATA: begin
                if (idx_q == IDX_LAST) nxt_st = CRC_LO;
                else begin
                  nxt_st = DATA;
                  idx_d  = idx_q + 1'b1;
                end
              end
              CRC_LO:  nxt_st = CRC_HI;
              CRC_HI:  nxt_st = DLE2;
              DLE2:    nxt_st = ETX;
              LT_DLE:  nxt_st = LT_LSE;
              LT_LSE:  nxt_st = LT_CLSE;
              default: nxt_st = IDLE;
            endcase
            state_d = nxt_st;
            if (nxt_st == IDLE) begin
              busy_d = 1'b0;
              done_d = 1'b1;
            end else begin
              nxt_byte = sym_byte(nxt_st, idx_d, req_q, crc_q);
              sym_d    = nxt_byte;
              if (feeds_crc(nxt_st)) crc_d = crc_byte(crc_q, nxt_byte);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      idx_q     <= '0;
      stuff_q   <= 1'b0;
      crc_q     <= CRC_INIT;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      idx_q     <= idx_d;
      stuff_q   <= stuff_d;
      crc_q     <= crc_d;
    end
  end

  always_ff @(posedge sb_clk) begin
    req_q <= req_d;
    sym_q <= sym_d;
  end

  // Line is forced idle whenever no frame is active, including during reset
  always_comb begin
    sbtx = 1'b1;
    if (busy_q) begin
      if (bit_cnt_q == 4'd0)      sbtx = 1'b0;
      else if (bit_cnt_q == 4'd9) sbtx = 1'b1;
      else                        sbtx = sym_q[3'(bit_cnt_q - 4'd1)];
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sb_tx_framer.sv
// Randomized scoreboard bench for sb_tx_framer: a frame-level reference model queues
// expected symbols; a line monitor reassembles sbtx per frame and compares.
module tb_sb_tx_framer;

  logic        sb_clk = 1'b0;
  logic        rst;
  logic        at_req, at_cmd, at_rw, at_with_data, lt_req, disconnect, use4;
  logic [7:0]  at_addr, lt_lse;
  logic [6:0]  at_len;
  logic [23:0] at_data;
  logic        at_req1, lt_req1, at_req4, lt_req4;
  logic        busy1, done1, sbtx1, busy4, done4, sbtx4;
  logic        busy_m, done_m, sbtx_m;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_bytes[$];
  int         exp_len[$];
  logic       mon_bits[$];
  logic       prev_busy = 1'b0;

  always #5 sb_clk = ~sb_clk;

  assign at_req1 = at_req & ~use4;
  assign lt_req1 = lt_req & ~use4;
  assign at_req4 = at_req & use4;
  assign lt_req4 = lt_req & use4;
  assign busy_m  = use4 ? busy4 : busy1;
  assign done_m  = use4 ? done4 : done1;
  assign sbtx_m  = use4 ? sbtx4 : sbtx1;

  sb_tx_framer #(.BIT_CYCLES(1)) dut1 (
    .sb_clk(sb_clk), .rst(rst), .at_req(at_req1), .at_cmd(at_cmd), .at_addr(at_addr),
    .at_rw(at_rw), .at_len(at_len), .at_with_data(at_with_data), .at_data(at_data),
    .lt_req(lt_req1), .lt_lse(lt_lse), .disconnect(disconnect),
    .busy(busy1), .done(done1), .sbtx(sbtx1));

  sb_tx_framer #(.BIT_CYCLES(4)) dut4 (
    .sb_clk(sb_clk), .rst(rst), .at_req(at_req4), .at_cmd(at_cmd), .at_addr(at_addr),
    .at_rw(at_rw), .at_len(at_len), .at_with_data(at_with_data), .at_data(at_data),
    .lt_req(lt_req4), .lt_lse(lt_lse), .disconnect(disconnect),
    .busy(busy4), .done(done4), .sbtx(sbtx4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] crc_add(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[15] != b[i]) r = (r << 1) ^ 16'h8005;
      else               r = r << 1;
    end
    return r;
  endfunction

  task automatic model_at(input logic cmd, input logic [7:0] addr, input logic rw,
                          input logic [6:0] len, input logic wd, input logic [23:0] data);
    logic [7:0]  body[$];
    logic [7:0]  stx;
    logic [15:0] c;
    int          n;
    stx = cmd ? 8'h05 : 8'h04;
    body.push_back(addr);
    body.push_back({rw, len});
    if (wd) for (int i = 0; i < 3; i++) body.push_back(data[8*i +: 8]);
    c = crc_add(16'hFFFF, stx);
    foreach (body[i]) c = crc_add(c, body[i]);
    body.push_back(c[7:0]);
    body.push_back(c[15:8]);
    exp_bytes.push_back(8'hFE);
    exp_bytes.push_back(stx);
    n = 2;
    foreach (body[i]) begin
      exp_bytes.push_back(body[i]);
      n++;
      if (body[i] == 8'hFE) begin
        exp_bytes.push_back(body[i]);
        n++;
      end
    end
    exp_bytes.push_back(8'hFE);
    exp_bytes.push_back(8'h40);
    exp_len.push_back(n + 2);
  endtask

  task automatic model_lt(input logic [7:0] lse);
    exp_bytes.push_back(8'hFE);
    exp_bytes.push_back(lse);
    exp_bytes.push_back(~lse);
    exp_len.push_back(3);
  endtask

  task automatic check_frame();
    logic       exp_bits[$];
    logic [7:0] b;
    logic       bv;
    int         n, bc, bad, lim;
    bc = use4 ? 4 : 1;
    check("done_after_last_bit", {30'd0, prev_busy, busy_m}, 32'd2);
    if (exp_len.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_frame: got frame of %0d cycles, required none", mon_bits.size());
    end else begin
      n = exp_len.pop_front();
      for (int k = 0; k < n; k++) begin
        b = exp_bytes.pop_front();
        for (int j = 0; j < 10; j++) begin
          bv = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
          for (int r = 0; r < bc; r++) exp_bits.push_back(bv);
        end
      end
      check("frame_busy_cycles", mon_bits.size(), exp_bits.size());
      bad = -1;
      lim = (mon_bits.size() < exp_bits.size()) ? mon_bits.size() : exp_bits.size();
      for (int i = 0; i < lim; i++) begin
        if (mon_bits[i] !== exp_bits[i]) begin
          bad = i;
          break;
        end
      end
      n_tests++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL frame_bits: cycle %0d (symbol %0d) got %b, required %b",
                 bad, bad / (10 * bc), mon_bits[bad], exp_bits[bad]);
      end
    end
  endtask

  // Line monitor: collects every busy cycle, judges the frame on the done pulse
  always @(negedge sb_clk) begin
    if (!rst) begin
      mon_bits.delete();
      prev_busy = 1'b0;
    end else begin
      if (busy_m) mon_bits.push_back(sbtx_m);
      else check("idle_sbtx_high", {31'd0, sbtx_m}, 32'd1);
      if (done_m) begin
        check_frame();
        mon_bits.delete();
      end else if (!busy_m) begin
        mon_bits.delete();
      end
      prev_busy = busy_m;
    end
  end

  task automatic tick();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy_m && k < 5000) begin
      tick();
      k++;
    end
    if (k >= 5000) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle_timeout: busy still %b after %0d cycles, required 0", busy_m, k);
    end
  endtask

  task automatic issue_at(input logic cmd, input logic [7:0] addr, input logic rw,
                          input logic [6:0] len, input logic wd, input logic [23:0] data,
                          input logic push);
    at_cmd = cmd; at_addr = addr; at_rw = rw; at_len = len;
    at_with_data = wd; at_data = data; at_req = 1'b1;
    tick();
    at_req = 1'b0;
    check("accept_busy", {31'd0, busy_m}, 32'd1);
    check("accept_start_bit", {31'd0, sbtx_m}, 32'd0);
    if (push) model_at(cmd, addr, rw, len, wd, data);
  endtask

  task automatic issue_lt(input logic [7:0] lse, input logic push);
    lt_lse = lse;
    lt_req = 1'b1;
    tick();
    lt_req = 1'b0;
    check("accept_busy", {31'd0, busy_m}, 32'd1);
    check("accept_start_bit", {31'd0, sbtx_m}, 32'd0);
    if (push) model_lt(lse);
  endtask

  function automatic logic [7:0] rnd_byte();
    return ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
  endfunction

  initial begin
    rst = 1'b1; at_req = 0; lt_req = 0; disconnect = 0; use4 = 0;
    at_cmd = 0; at_addr = 0; at_rw = 0; at_len = 0; at_with_data = 0; at_data = 0; lt_lse = 0;
    #1 rst = 1'b0;
    tick(); tick();
    check("reset_busy1", {31'd0, busy1}, 32'd0);
    check("reset_sbtx1", {31'd0, sbtx1}, 32'd1);
    check("reset_done1", {31'd0, done1}, 32'd0);
    check("reset_busy4", {31'd0, busy4}, 32'd0);
    check("reset_sbtx4", {31'd0, sbtx4}, 32'd1);
    rst = 1'b1;
    tick(); tick();

    // AT read command, no data
    issue_at(1'b1, 8'h0C, 1'b0, 7'd3, 1'b0, 24'h0, 1'b1);
    wait_idle();
    // AT write response with stuffed address and data byte
    issue_at(1'b0, 8'hFE, 1'b1, 7'd3, 1'b1, 24'h00FE11, 1'b1);
    wait_idle();
    // LT frame
    issue_lt(8'h80, 1'b1);
    wait_idle();

    // Simultaneous requests: LT wins, AT dropped; AT pulsed mid-frame ignored
    at_cmd = 1; at_addr = 8'h22; at_rw = 0; at_len = 7'd1; at_with_data = 0;
    lt_lse = 8'h3C; at_req = 1; lt_req = 1;
    tick();
    at_req = 0; lt_req = 0;
    model_lt(8'h3C);
    repeat (10) tick();
    at_req = 1;
    tick();
    at_req = 0;
    wait_idle();
    repeat (5) tick();
    check("no_extra_frame", {31'd0, busy_m}, 32'd0);

    // Abort during DATA, then a clean frame must use a reseeded CRC
    issue_at(1'b1, 8'h11, 1'b0, 7'd5, 1'b1, 24'h123456, 1'b0);
    repeat (45) tick();
    disconnect = 1;
    tick();
    check("abort_busy", {31'd0, busy_m}, 32'd0);
    check("abort_sbtx", {31'd0, sbtx_m}, 32'd1);
    check("abort_done", {31'd0, done_m}, 32'd0);
    at_req = 1;
    tick(); tick();
    check("no_accept_in_disconnect", {31'd0, busy_m}, 32'd0);
    at_req = 0; disconnect = 0;
    tick();
    issue_at(1'b1, 8'h11, 1'b0, 7'd5, 1'b1, 24'h123456, 1'b1);
    wait_idle();

    // Randomized traffic, back-to-back where the done cycle allows it
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) issue_lt(rnd_byte(), 1'b1);
      else issue_at(1'($urandom), rnd_byte(), 1'($urandom), 7'($urandom), 1'($urandom),
                    {rnd_byte(), rnd_byte(), rnd_byte()}, 1'b1);
      wait_idle();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) tick();
    end

    // Four cycles per bit
    repeat (2) tick();
    use4 = 1;
    issue_lt(8'h80, 1'b1);
    wait_idle();
    issue_at(1'b0, 8'hFE, 1'b1, 7'h7E, 1'b1, 24'hFE00FE, 1'b1);
    wait_idle();

    // Asynchronous reset mid-frame
    issue_lt(8'h5A, 1'b0);
    repeat (30) tick();
    #2 rst = 1'b0;
    #1;
    check("rst_async_sbtx", {31'd0, sbtx4}, 32'd1);
    check("rst_async_busy", {31'd0, busy4}, 32'd0);
    check("rst_async_done", {31'd0, done4}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    issue_lt(8'hA5, 1'b1);
    wait_idle();

    repeat (5) tick();
    check("scoreboard_drained", exp_len.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
